// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register for the EX->MEM and
// MEM->WB boundaries. It carries an opaque payload plus a halted flag and
// supports freeze (stall), flush bubble insertion, sticky halt tracking and a
// saturating stall-cycle counter.
// Optional build macro PIPE_STAGE_SKID_EN adds a second (skid) entry and
// registers in_ready, which removes the out_ready->in_ready combinational path.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W     = 72,
  parameter int                   CNT_W         = 16,
  parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_halted,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_halted,
  output logic                 halt_seen,
  output logic [CNT_W-1:0]     stall_cycles
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 halted_q;
  logic                 halt_seen_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic                 in_fire;
  logic                 out_fire;

  assign out_valid    = valid_q & ~stall;
  assign out_fire     = out_valid & out_ready;
  assign in_fire      = in_valid & in_ready;
  assign out_payload  = payload_q;
  assign out_halted   = halted_q;
  assign halt_seen    = halt_seen_q;
  assign stall_cycles = stall_cnt_q;

  // Stall-cycle counter: counts every stalled cycle (flush included), no wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Sticky halt flag: set when a halted payload is accepted; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_seen_q <= 1'b0;
    end else if (in_fire && in_halted) begin
      halt_seen_q <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  logic                 skid_valid_q;
  logic [PAYLOAD_W-1:0] skid_payload_q;
  logic                 skid_halted_q;
  logic                 skid_valid_n;
  logic                 in_ready_q;

  // in_ready_q is loaded with the next-state view of skid/halt, so it always
  // equals ~skid_valid_q & ~halt_seen_q without depending on out_ready.
  assign in_ready = in_ready_q & ~stall & ~flush;

  // Skid occupancy next state: fills when main is blocked, drains on out_fire.
  always_comb begin
    skid_valid_n = skid_valid_q;
    if (flush) begin
      skid_valid_n = 1'b0;
    end else if (!stall) begin
      if (skid_valid_q && out_fire) begin
        skid_valid_n = 1'b0;
      end else if (in_fire && valid_q && !out_fire) begin
        skid_valid_n = 1'b1;
      end
    end
  end

  // Skid entry and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q   <= 1'b0;
      skid_payload_q <= '0;
      skid_halted_q  <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= ~skid_valid_n & ~(halt_seen_q | (in_fire & in_halted));
      if (!flush && !stall && in_fire && valid_q && !out_fire) begin
        skid_payload_q <= in_payload;
        skid_halted_q  <= in_halted;
      end
    end
  end

  // Main entry: refilled from skid first to keep FIFO order, else from input.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= RESET_PAYLOAD;
      halted_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (skid_valid_q) begin
        if (out_fire) begin
          payload_q <= skid_payload_q;
          halted_q  <= skid_halted_q;
        end
      end else if (in_fire && (!valid_q || out_fire)) begin
        valid_q   <= 1'b1;
        payload_q <= in_payload;
        halted_q  <= in_halted;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

`else

  assign in_ready = ~stall & ~flush & ~halt_seen_q & (~valid_q | out_ready);

  // Single entry: capture on in_fire (covers simultaneous drain), clear on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= RESET_PAYLOAD;
      halted_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (in_fire) begin
        valid_q   <= 1'b1;
        payload_q <= in_payload;
        halted_q  <= in_halted;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline register for the EX→MEM / MEM→WB boundaries; replaces the hand-written per-field stage registers.
- Carries an opaque payload plus a `halted` flag under a valid/ready handshake, with:
  - external freeze (cache busy),
  - synchronous flush for bubble insertion,
  - sticky halt tracking,
  - a saturating stall-cycle counter for performance debug.

Parameters:
- PAYLOAD_W, 72, payload width in bits (ctrl bits + alu_result + store data + rd).
- CNT_W, 16, width of the stall-cycle counter.
- RESET_PAYLOAD, 0, value loaded into out_payload on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage can accept this cycle
- in_payload  in  PAYLOAD_W  upstream payload
- in_halted  in  1  payload is the halt instruction
- stall  in  1  freeze (cache busy); stage holds state
- flush  in  1  discard the held entry and accept nothing this cycle
- out_valid  out  1  stage holds a payload visible downstream
- out_ready  in  1  downstream accepts
- out_payload  out  PAYLOAD_W  held payload
- out_halted  out  1  halted flag of held payload
- halt_seen  out  1  sticky: a halted payload has been accepted
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (sync, highest priority) sets:
  - valid_q=0, out_payload=RESET_PAYLOAD, out_halted=0, halt_seen=0, stall_cycles=0;
  - the skid entry, when compiled in, to empty.
- Combinational output and handshake terms:
  - out_valid = valid_q & ~stall.
  - out_fire = out_valid & out_ready.
  - in_fire = in_valid & in_ready.
- in_ready (base build) = ~stall & ~flush & ~halt_seen & (~valid_q | out_ready). It is combinational from out_ready.
- Priority per edge: reset > flush > stall > normal.
- flush=1:
  - valid_q←0 next edge; payload regs keep their old value (don't-care);
  - in_ready=0, so no capture;
  - flush wins over a simultaneous stall.
- stall=1, flush=0:
  - all registers hold;
  - out_valid is masked to 0, so no transfer occurs either side;
  - stall_cycles increments, saturating at 2^CNT_W-1 with no wrap.
- Normal operation:
  - in_fire: payload/halted latched, valid_q←1. This covers simultaneous in_fire and out_fire, giving back-to-back throughput of 1/cycle.
  - out_fire without in_fire: valid_q←0.
  - Neither: hold.
- Latency: a payload accepted at edge N is visible on out_* after edge N (1 cycle).
- Halt handling:
  - On in_fire with in_halted=1: halt_seen←1 at the same edge.
  - From then on in_ready=0 until reset; the halted entry still drains downstream normally.
  - Flush does not clear halt_seen.
- Data stability: out_payload and out_halted must not change while out_valid=1 & ~out_ready.
- Reset mid-operation: any held entry is dropped; no out_fire occurs on the reset edge.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - Adds a second (skid) entry; in_ready becomes a registered signal: in_ready_q = ~skid_valid & ~halt_seen, then masked by ~stall & ~flush.
  - When main is full, out_ready=0 and in_fire, the payload goes to skid.
  - On the next out_fire, skid moves to main.
  - Ordering is strictly FIFO.
  - Flush empties both entries.
  - Full throughput with no combinational out_ready→in_ready path.
- Undefined: single entry, with combinational in_ready as above; no skid registers are synthesised.

Test Plan:
- Streaming: reset, then in_valid=1 with payloads 0x1,0x2,0x3 on consecutive cycles, out_ready=1 → out_payload 0x1,0x2,0x3 on the next three cycles, out_valid=1 each, no gaps.
- Backpressure: hold 0xA, out_ready=0 for 3 cycles, in_valid=1 with 0xB → base build: in_ready=0, out_payload stays 0xA; after out_ready=1, 0xA then 0xB are delivered. Skid build: 0xB accepted into skid once, then in_ready=0.
- Stall: valid 0x5 held, stall=1 for 4 cycles with out_ready=1 → out_valid=0, in_ready=0, stall_cycles=4; after release, 0x5 is delivered exactly once.
- Flush: entry 0x7 held, flush=1 together with stall=1 and in_valid=1 (0x8) → next cycle out_valid=0; 0x8 not captured; stall_cycles still increments by 1.
- Halt: accept 0x9 with in_halted=1, then in_valid=1 continuously → halt_seen=1, in_ready=0 forever; 0x9 delivered with out_halted=1; a later flush leaves halt_seen=1.
- Counter saturation (CNT_W=4): stall=1 for 20 cycles → stall_cycles=15 and holds; synchronous reset returns it to 0.
